layer_result_pingpong_mem: RTL and testbench

Parametrised, double-buffered (ping-pong) result store for one CNN layer's output feature map. The producing layer writes a full MAP_H×MAP_W map into one bank while the consuming layer reads the previously completed map from the other bank. Bank ownership is handed over by explicit done/release pulses. It replaces single-bank, fixed-size layer result memories between any two layer engines.

---
 rtl/layer_mem_pkg.sv | 25 ++
 rtl/layer_result_bank.sv | 23 ++
 rtl/layer_result_pingpong_mem.sv | 121 ++++++++++++
 tb/tb_layer_result_pingpong_mem.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_mem_pkg.sv
// Shared types and address helper for the ping-pong layer result store.
package layer_mem_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  typedef struct packed {
    logic        ok;
    logic [31:0] addr;
  } lin_addr_t;

  // Row-major linear address plus range check against the map geometry.
  function automatic lin_addr_t lin_addr(input logic [31:0] row,
                                         input logic [31:0] col,
                                         input int unsigned map_w,
                                         input int unsigned map_h);
    lin_addr_t r;
    r.ok   = (row < map_h) && (col < map_w);
    r.addr = row * map_w + col;
    return r;
  endfunction

endpackage

// File: rtl/layer_result_bank.sv
// One feature-map bank: synchronous write, registered read with read-enable.
module layer_result_bank #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 196,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_result_pingpong_mem.sv
// Double-buffered layer result store; banks change hands on save_done / read_release.
module layer_result_pingpong_mem
  import layer_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned MAP_W  = 14,
  parameter int unsigned MAP_H  = 14,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [ADDR_W-1:0] save_row_addr,
  input  logic [ADDR_W-1:0] save_col_addr,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              save_done,
  input  logic              read_signal,
  input  logic [ADDR_W-1:0] read_row_addr,
  input  logic [ADDR_W-1:0] read_col_addr,
  input  logic              read_release,
  output logic              wr_ready,
  output logic              rd_ready,
  output logic [DATA_W-1:0] result_output,
  output logic              result_valid,
  output logic              err_flag
);

  localparam int unsigned DEPTH = MAP_H * MAP_W;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  bank_state_e       state   [2];
  bank_state_e       state_n [2];
  logic              wr_sel, wr_sel_n, rd_sel, rd_sel_n;
  lin_addr_t         wr_la, rd_la;
  logic              wr_accept, rd_accept, err_event;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic              rd_valid_q, rd_bank_q, err_q;
  logic [DATA_W-1:0] bank_rdata [2];

  always_comb begin
    wr_la     = lin_addr(32'(save_row_addr), 32'(save_col_addr), MAP_W, MAP_H);
    rd_la     = lin_addr(32'(read_row_addr), 32'(read_col_addr), MAP_W, MAP_H);
    wr_addr   = AW'(wr_la.addr);
    rd_addr   = AW'(rd_la.addr);
    wr_accept = save_enable && wr_ready && wr_la.ok;
    rd_accept = read_signal && rd_ready && rd_la.ok;
    err_event = (save_enable && !wr_accept) || (save_done && !wr_ready) ||
                (read_signal && !rd_accept) || (read_release && !rd_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state[0] <= BANK_EMPTY;
      state[1] <= BANK_EMPTY;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      state  <= state_n;
      wr_sel <= wr_sel_n;
      rd_sel <= rd_sel_n;
    end
  end

  // The write bank is EMPTY and the read bank FULL whenever either handover
  // fires, so simultaneous save_done/read_release always touch different banks.
  always_comb begin
    state_n  = state;
    wr_sel_n = wr_sel;
    rd_sel_n = rd_sel;
    if (save_done && wr_ready) begin
      state_n[wr_sel] = BANK_FULL;
      wr_sel_n        = ~wr_sel;
    end
    if (read_release && rd_ready) begin
      state_n[rd_sel] = BANK_EMPTY;
      rd_sel_n        = ~rd_sel;
    end
  end

  always_comb begin
    wr_ready = (state[wr_sel] == BANK_EMPTY);
    rd_ready = (state[rd_sel] == BANK_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      rd_bank_q  <= rd_sel;
      if (err_event) err_q <= 1'b1;
    end
  end

  layer_result_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (wr_accept && !wr_sel),
    .waddr (wr_addr),
    .wdata (store_data_in),
    .re    (rd_accept && !rd_sel),
    .raddr (rd_addr),
    .rdata (bank_rdata[0])
  );

  layer_result_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (wr_accept && wr_sel),
    .waddr (wr_addr),
    .wdata (store_data_in),
    .re    (rd_accept && rd_sel),
    .raddr (rd_addr),
    .rdata (bank_rdata[1])
  );

  assign result_output = rd_valid_q ? bank_rdata[rd_bank_q] : '0;
  assign result_valid  = rd_valid_q;
  assign err_flag      = err_q;

endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// Directed bench for layer_result_pingpong_mem with a per-cycle reference model.
module tb_layer_result_pingpong_mem;

  localparam int DW = 16;
  localparam int MW = 4;
  localparam int MH = 3;
  localparam int AD = 16;

  logic          clk;
  logic          rst;
  logic          save_enable;
  logic [AD-1:0] save_row_addr;
  logic [AD-1:0] save_col_addr;
  logic [DW-1:0] store_data_in;
  logic          save_done;
  logic          read_signal;
  logic [AD-1:0] read_row_addr;
  logic [AD-1:0] read_col_addr;
  logic          read_release;
  logic          wr_ready;
  logic          rd_ready;
  logic [DW-1:0] result_output;
  logic          result_valid;
  logic          err_flag;

  int checks   = 0;
  int failures = 0;

  layer_result_pingpong_mem #(.DATA_W(DW), .MAP_W(MW), .MAP_H(MH), .ADDR_W(AD)) dut (
    .clk           (clk),
    .rst           (rst),
    .save_enable   (save_enable),
    .save_row_addr (save_row_addr),
    .save_col_addr (save_col_addr),
    .store_data_in (store_data_in),
    .save_done     (save_done),
    .read_signal   (read_signal),
    .read_row_addr (read_row_addr),
    .read_col_addr (read_col_addr),
    .read_release  (read_release),
    .wr_ready      (wr_ready),
    .rd_ready      (rd_ready),
    .result_output (result_output),
    .result_valid  (result_valid),
    .err_flag      (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: two banks with a full flag each, pointers, sticky error.
  logic [DW-1:0] m_mem [2][MH*MW];
  logic          m_full [2];
  logic          m_ws, m_rs, m_err, m_val;
  logic [DW-1:0] m_out;
  logic          m_wr_ready, m_rd_ready, w_ok, r_ok;
  int            w_idx, r_idx;

  assign m_wr_ready = !m_full[m_ws];
  assign m_rd_ready = m_full[m_rs];
  assign w_ok  = save_enable && m_wr_ready && (save_row_addr < MH) && (save_col_addr < MW);
  assign r_ok  = read_signal && m_rd_ready && (read_row_addr < MH) && (read_col_addr < MW);
  assign w_idx = int'(save_row_addr) * MW + int'(save_col_addr);
  assign r_idx = int'(read_row_addr) * MW + int'(read_col_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_full[0] <= 1'b0;
      m_full[1] <= 1'b0;
      m_ws      <= 1'b0;
      m_rs      <= 1'b0;
      m_err     <= 1'b0;
      m_val     <= 1'b0;
      m_out     <= '0;
    end else begin
      if (w_ok) m_mem[m_ws][w_idx] <= store_data_in;
      m_val <= r_ok;
      m_out <= r_ok ? m_mem[m_rs][r_idx] : '0;
      if (save_done && m_wr_ready) begin
        m_full[m_ws] <= 1'b1;
        m_ws         <= !m_ws;
      end
      if (read_release && m_rd_ready) begin
        m_full[m_rs] <= 1'b0;
        m_rs         <= !m_rs;
      end
      if ((save_enable && !w_ok) || (save_done && !m_wr_ready) ||
          (read_signal && !r_ok) || (read_release && !m_rd_ready))
        m_err <= 1'b1;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk1 ("cyc_wr_ready", wr_ready, m_wr_ready);
    chk1 ("cyc_rd_ready", rd_ready, m_rd_ready);
    chk1 ("cyc_valid",    result_valid, m_val);
    chk16("cyc_output",   result_output, m_out);
    chk1 ("cyc_err",      err_flag, m_err);
  end

  task automatic cyc(input logic se, input int sr, input int sc, input int sd, input logic dn,
                     input logic rs, input int rr, input int rc, input logic rl);
    save_enable   = se;
    save_row_addr = AD'(sr);
    save_col_addr = AD'(sc);
    store_data_in = DW'(sd);
    save_done     = dn;
    read_signal   = rs;
    read_row_addr = AD'(rr);
    read_col_addr = AD'(rc);
    read_release  = rl;
    @(posedge clk);
    #2;
    save_enable  = 1'b0;
    save_done    = 1'b0;
    read_signal  = 1'b0;
    read_release = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    save_enable = 1'b0; save_row_addr = '0; save_col_addr = '0; store_data_in = '0;
    save_done = 1'b0; read_signal = 1'b0; read_row_addr = '0; read_col_addr = '0;
    read_release = 1'b0;
    #2;
    chk1 ("rst_wr_ready", wr_ready, 1'b1);
    chk1 ("rst_rd_ready", rd_ready, 1'b0);
    chk1 ("rst_valid",    result_valid, 1'b0);
    chk16("rst_output",   result_output, 16'h0000);
    chk1 ("rst_err",      err_flag, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // read before any bank is full
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk1 ("early_rd_valid", result_valid, 1'b0);
    chk16("early_rd_out",   result_output, 16'h0000);
    chk1 ("early_rd_err",   err_flag, 1'b1);
    pulse_reset();
    chk1 ("err_cleared", err_flag, 1'b0);

    // out-of-range row on write
    cyc(1, 3, 0, 16'h0bad, 0, 0, 0, 0, 0);
    chk1 ("oor_wr_err", err_flag, 1'b1);
    chk1 ("model_oor_wr_err", m_err, 1'b1);
    pulse_reset();

    // fill bank0
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++)
        cyc(1, r, c, r * 16 + c, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk1("b0_done_rd_ready", rd_ready, 1'b1);
    chk1("b0_done_wr_ready", wr_ready, 1'b1);

    cyc(0, 0, 0, 0, 0, 1, 2, 3, 0);
    chk16("rd_2_3",       result_output, 16'h0023);
    chk16("model_rd_2_3", m_out, 16'h0023);
    chk1 ("rd_2_3_valid", result_valid, 1'b1);
    chk1 ("no_err_yet",   err_flag, 1'b0);

    // fill bank1 while streaming reads from bank0; final write shares the save_done cycle
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++)
        cyc(1, r, c, 16'h100 + r * 16 + c, (r == MH - 1 && c == MW - 1), 1, r, c, 0);
    chk1("both_full_wr_ready", wr_ready, 1'b0);
    chk1("both_full_rd_ready", rd_ready, 1'b1);
    chk1("both_full_err",      err_flag, 1'b0);

    cyc(1, 0, 0, 16'hffff, 0, 0, 0, 0, 0);
    chk1("drop_wr_err", err_flag, 1'b1);

    // read in the release cycle still returns data from the released bank
    cyc(0, 0, 0, 0, 0, 1, 2, 2, 1);
    chk16("rd_on_release",  result_output, 16'h0022);
    chk1 ("release_rd_ready", rd_ready, 1'b1);
    chk1 ("release_wr_ready", wr_ready, 1'b1);

    cyc(0, 0, 0, 0, 0, 1, 1, 1, 0);
    chk16("rd_b1_1_1",       result_output, 16'h0111);
    chk16("model_rd_b1_1_1", m_out, 16'h0111);

    cyc(0, 0, 0, 0, 0, 1, 0, 4, 0);
    chk16("oor_rd_out",   result_output, 16'h0000);
    chk1 ("oor_rd_valid", result_valid, 1'b0);

    // refill bank0 after an out-of-range write that would alias (1,0) without the range check
    cyc(1, 0, 4, 16'hbeef, 0, 0, 0, 0, 0);
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++) begin
        if (r == MH - 1 && c == MW - 1)
          cyc(1, r, c, 16'h200 + r * 16 + c, 1, 1, 2, 3, 1);
        else
          cyc(1, r, c, 16'h200 + r * 16 + c, 0, 0, 0, 0, 0);
      end
    chk1 ("swap_rd_ready", rd_ready, 1'b1);
    chk1 ("swap_wr_ready", wr_ready, 1'b1);
    chk16("swap_rd_data",  result_output, 16'h0123);

    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk16("rd_b0_1_0", result_output, 16'h0210);
    cyc(0, 0, 0, 0, 0, 1, 2, 3, 0);
    chk16("rd_b0_2_3", result_output, 16'h0223);

    // reset mid-fill of bank1 with bank0 full and a read in flight
    cyc(1, 0, 0, 16'h0300, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 16'h0301, 0, 1, 0, 1, 0);
    chk16("pre_rst_out", result_output, 16'h0201);
    rst = 1'b0;
    #1;
    chk1 ("mid_rst_wr_ready", wr_ready, 1'b1);
    chk1 ("mid_rst_rd_ready", rd_ready, 1'b0);
    chk1 ("mid_rst_valid",    result_valid, 1'b0);
    chk16("mid_rst_output",   result_output, 16'h0000);
    chk1 ("mid_rst_err",      err_flag, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
